// File: rtl/stream_mux_rr.sv
// stream_mux_rr: per-channel FWFT FIFOs feeding a round-robin arbiter onto one AXI-Stream output
module stream_mux_rr #(
    parameter int DW = 32,
    parameter int NCH = 4,
    parameter int FIFO_AW = 8,
    parameter int PACKET_MODE = 1,
    parameter int MAX_BURST = 16,
    localparam int CW = $clog2(NCH)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [NCH-1:0]    s_tvalid,
    output logic [NCH-1:0]    s_tready,
    input  logic [NCH*DW-1:0] s_tdata,
    input  logic [NCH-1:0]    s_tlast,
    input  logic [NCH-1:0]    s_arb_suppress,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DW-1:0]     m_tdata,
    output logic              m_tlast,
    output logic [CW-1:0]     m_tid,
    input  logic              clear_drops,
    output logic [NCH*16-1:0] dropped
);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [CW-1:0] grant, grant_n, last_grant, last_grant_n, pick, cand;
    logic [BW-1:0] burst_cnt, burst_cnt_n;
    logic [NCH-1:0] full, empty, rd_en, elig;
    logic [NCH-1:0][DW:0] head;
    logic found, hs;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DW:0] mem [2**FIFO_AW];
        logic [FIFO_AW:0] wr_ptr, rd_ptr;
        logic [15:0] drop_cnt;
        assign full[i] = wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0] && wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW];
        assign empty[i] = wr_ptr == rd_ptr;
        assign head[i] = mem[rd_ptr[FIFO_AW-1:0]];
        assign rd_en[i] = hs && grant == CW'(i);
        assign s_tready[i] = ~full[i];
        assign dropped[i*16 +: 16] = drop_cnt;
        always_ff @(posedge aclk) begin
            if (s_tvalid[i] && !full[i]) mem[wr_ptr[FIFO_AW-1:0]] <= {s_tlast[i], s_tdata[i*DW +: DW]};
        end
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                drop_cnt <= '0;
            end else begin
                if (s_tvalid[i] && !full[i]) wr_ptr <= wr_ptr + (FIFO_AW + 1)'(1);
                if (rd_en[i]) rd_ptr <= rd_ptr + (FIFO_AW + 1)'(1);
                drop_cnt <= clear_drops ? '0 : (s_tvalid[i] && full[i] && drop_cnt != 16'hFFFF) ? drop_cnt + 16'd1 : drop_cnt;
            end
        end
    end

    assign m_tvalid = state == GRANT && !empty[grant];
    assign m_tdata = m_tvalid ? head[grant][DW-1:0] : '0;
    assign m_tlast = m_tvalid && head[grant][DW];
    assign m_tid = grant;
    assign hs = m_tvalid && m_tready;
    assign elig = ~empty & ~s_arb_suppress;

    // search starts one past the previous winner and wraps
    always_comb begin
        found = 1'b0;
        pick = '0;
        cand = last_grant;
        for (int k = 0; k < NCH; k++) begin
            cand = (cand == CW'(NCH - 1)) ? '0 : cand + CW'(1);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick = cand;
            end
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_grant_n = last_grant;
        burst_cnt_n = burst_cnt;
        if (state == IDLE) begin
            if (found) begin
                state_n = GRANT;
                grant_n = pick;
                burst_cnt_n = '0;
            end
        end else begin
            burst_cnt_n = hs ? burst_cnt + BW'(1) : burst_cnt;
            if (PACKET_MODE != 0 ? (hs && m_tlast) : ((hs && burst_cnt == BW'(MAX_BURST - 1)) || empty[grant])) begin
                state_n = IDLE;
                last_grant_n = grant;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            grant <= '0;
            last_grant <= CW'(NCH - 1);
            burst_cnt <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            last_grant <= last_grant_n;
            burst_cnt <= burst_cnt_n;
        end
    end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- N-channel successor to the two-input stream multiplexer used in the gateware testbenches.
- Each input channel has its own first-word-fallthrough FIFO.
- A round-robin arbiter forwards one channel at a time to a single AXI-Stream-style output, and re-arbitrates either on packet boundaries or on burst/empty.
- Output transfers obey TREADY strictly. Every channel has input backpressure, a drop counter and the source channel ID on the output.

Parameters:
- DW, 32, tdata width per channel.
- NCH, 4, number of input channels (2..16).
- FIFO_AW, 8, log2 of per-channel FIFO depth (depth = 2**FIFO_AW).
- PACKET_MODE, 1, 1 = hold grant until the TLAST word is accepted; 0 = hold until FIFO empty or MAX_BURST words.
- MAX_BURST, 16, word-mode burst limit (1..2**FIFO_AW).
- CW, $clog2(NCH), channel index width (derived, not overridden).

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- s_tvalid  in  NCH  per-channel valid.
- s_tready  out  NCH  per-channel ~full.
- s_tdata  in  NCH*DW  channel i occupies bits [i*DW +: DW].
- s_tlast  in  NCH  per-channel packet end.
- s_arb_suppress  in  NCH  1 = channel not eligible for a new grant.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tdata  out  DW  output data.
- m_tlast  out  1  output packet end.
- m_tid  out  CW  index of the granted channel.
- clear_drops  in  1  synchronous clear of all drop counters.
- dropped  out  NCH*16  per-channel saturating drop count, channel i at [i*16 +: 16].

Behaviour:
- Reset (async assert, sync-safe release):
  - all FIFO pointers = 0; state = IDLE; last_grant = NCH-1, so channel 0 wins first.
  - burst count = 0; dropped = 0.
  - m_tvalid = 0, m_tdata = 0, m_tlast = 0, m_tid = 0; s_tready = all 1.
  - RAM contents are not reset.
- FIFO:
  - Pointers carry one extra wrap bit. full = low bits equal and wrap bits differ; empty = pointers equal.
  - On s_tvalid[i] & ~full[i]: store {tlast, tdata} and advance the write pointer.
  - On s_tvalid[i] & full[i]: the word is discarded and dropped[i] increments, saturating at 0xFFFF.
- Flag timing:
  - full and empty are computed from registered pointers.
  - A read and a write to a full FIFO in the same cycle still drops the write.
  - A word written at edge k makes the FIFO non-empty in cycle k+1.
- clear_drops zeroes all counters. If a drop occurs in the same cycle, the clear wins.
- Arbiter FSM:
  - IDLE:
    - Eligible set = ~empty & ~s_arb_suppress.
    - Grant the first eligible channel searching last_grant+1 upward, wrapping modulo NCH.
    - Register grant; go to GRANT; burst count = 0.
    - If no channel is eligible, stay in IDLE.
  - GRANT:
    - m_tvalid = ~empty[grant]; m_tdata / m_tlast = FIFO head; m_tid = grant.
    - The read pointer advances only on m_tvalid & m_tready.
    - Suppress is ignored once a channel is granted.
  - GRANT exit when PACKET_MODE = 1:
    - Go to IDLE after the handshake of a word with tlast = 1; last_grant = grant.
    - If the FIFO empties mid-packet, hold the grant with m_tvalid = 0.
  - GRANT exit when PACKET_MODE = 0:
    - Go to IDLE when the FIFO is empty and no handshake occurs that cycle.
    - Also go to IDLE on the MAX_BURST-th handshake.
    - last_grant = grant.
- Output rules:
  - m_tvalid is never asserted in IDLE.
  - Once asserted, m_tdata and m_tlast hold stable until the handshake, per AXI-Stream.
- Latency:
  - A write at edge k into an empty mux in IDLE gives eligibility in cycle k+1, grant at edge k+1, and m_tvalid in cycle k+2.
  - Back-to-back words within a grant stream at 1 word per cycle.
  - Re-arbitration costs one idle cycle.
- Combinational paths: m_tvalid, m_tdata and m_tlast depend only on registered state and RAM, never combinationally on m_tready.

Test Plan:
- Packet round-robin: PACKET_MODE=1, NCH=4, each channel loads a 3-word packet (last word tlast=1), m_tready=1 -> m_tid sequence 0,0,0,1,1,1,2,2,2,3,3,3, with one idle cycle between packets. First m_tvalid arrives 2 cycles after the first write.
- Backpressure: toggle m_tready 1010... during a channel-2 packet of 0xA0..0xA4 -> each word appears exactly once, in order. m_tdata is stable while m_tready=0, and no word is skipped on the tlast word.
- Overflow: FIFO_AW=2, channel 1 writes 6 words with m_tready=0 -> s_tready[1] drops after 4 writes and dropped[1]=2. Then clear_drops -> 0. Forcing 0x10005 writes while full -> counter saturates at 0xFFFF.
- Word mode: PACKET_MODE=0, MAX_BURST=4, channels 0 and 3 each hold 10 words -> grant pattern is 4 from ch0, 4 from ch3, 4 from ch0, and so on. An empty channel yields early.
- Suppress and mid-packet stall: s_arb_suppress[1]=1 with ch1 non-empty -> ch1 is never granted. Ch0 packet with a 5-cycle input gap mid-packet -> grant held, m_tvalid=0 during the gap, resumes on ch0.
- Reset mid-packet: assert areset while a channel-2 packet is half transferred -> m_tvalid=0 immediately (async), FIFOs empty, next grant goes to channel 0.
